logic_gate_fifo: RTL and testbench

// - Parametrised successor to the single-bit two-input gate: WIDTH-bit bitwise gate unit with runtime op select.
// - Results are buffered in a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
// - Sits between stimulus/operand sources and downstream consumers that may stall.
// - Keeps a saturating count of accepted operations.

---
 rtl/logic_gate_fifo_if.sv | 24 ++
 rtl/logic_gate_fifo.sv | 118 +++++++++++
 tb/tb_logic_gate_fifo.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/logic_gate_fifo_if.sv
// rtl/logic_gate_fifo_if.sv - operand/result handshake bundle for logic_gate_fifo
// master drives operands and consumes results; slave is the gate FIFO.
interface logic_gate_fifo_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out2;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output A, B, op, in_valid, out_ready,
        input  in_ready, out2, out_valid
    );

    modport slave (
        input  A, B, op, in_valid, out_ready,
        output in_ready, out2, out_valid
    );
endinterface

// File: rtl/logic_gate_fifo.sv
// rtl/logic_gate_fifo.sv - WIDTH-bit bitwise gate with DEPTH-entry result FIFO and push counter
// Optional per-entry parity output enabled by LOGIC_GATE_FIFO_PARITY_EN.
module logic_gate_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    logic_gate_fifo_if.slave           bus,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                acc_cnt
`ifdef LOGIC_GATE_FIFO_PARITY_EN
    ,
    output logic                       out_parity
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [15:0]      acc_cnt_q, acc_cnt_d;

    logic             not_full;
    logic             not_empty;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] result;

    function automatic logic [WIDTH-1:0] gate_eval(input logic [2:0] sel,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (sel)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a & b);
            3'd4:    r = ~(a | b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = a;
            default: r = ~a;
        endcase
        return r;
    endfunction

    // Handshake flags come only from the registered level, never from in_valid/out_ready.
    assign not_full  = (level_q != FULL_LVL);
    assign not_empty = (level_q != '0);
    assign push      = bus.in_valid & not_full;
    assign pop       = bus.out_ready & not_empty;
    assign result    = gate_eval(bus.op, bus.A, bus.B);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        acc_cnt_d = acc_cnt_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (acc_cnt_q != 16'hFFFF) begin
                acc_cnt_d = acc_cnt_q + 16'd1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            acc_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    // Storage needs no reset: empty entries are masked at the output.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    assign bus.in_ready  = not_full;
    assign bus.out_valid = not_empty;
    assign bus.out2      = not_empty ? mem_q[rd_ptr_q] : '0;
    assign level         = level_q;
    assign acc_cnt       = acc_cnt_q;

`ifdef LOGIC_GATE_FIFO_PARITY_EN
    logic par_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            par_q[wr_ptr_q] <= ^result;
        end
    end

    assign out_parity = not_empty ? par_q[rd_ptr_q] : 1'b0;
`endif

endmodule

// File: tb/tb_logic_gate_fifo.sv
// tb/tb_logic_gate_fifo.sv - randomized and directed bench for logic_gate_fifo against a queue model
module tb_logic_gate_fifo;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic [2:0]  level;
    logic [15:0] acc_cnt;
`ifdef LOGIC_GATE_FIFO_PARITY_EN
    logic        out_parity;
`endif

    logic_gate_fifo_if #(.WIDTH(WIDTH)) bus ();

    logic_gate_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .level      (level),
        .acc_cnt    (acc_cnt)
`ifdef LOGIC_GATE_FIFO_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] model_q [$];
    int unsigned      model_acc = 0;
    logic [3:0]       truth [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Each op is a 2-input truth table indexed by {a_bit, b_bit}.
    function automatic logic [WIDTH-1:0] ref_gate(input logic [2:0] o, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic [3:0]       t;
        t = truth[o];
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = t[{a[i], b[i]}];
        end
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        logic [WIDTH-1:0] head;
        head = (model_q.size() == 0) ? '0 : model_q[0];
        check({tag, ".level"},     32'(level),         32'(model_q.size()));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(model_q.size() != 0));
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'(model_q.size() < DEPTH));
        check({tag, ".out2"},      32'(bus.out2),      32'(head));
        check({tag, ".acc_cnt"},   32'(acc_cnt),       model_acc);
`ifdef LOGIC_GATE_FIFO_PARITY_EN
        check({tag, ".parity"},    32'(out_parity),    32'(^head));
`endif
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare at the falling edge.
    task automatic step(input string tag, input logic r, input logic iv, input logic [2:0] o,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic ordy);
        logic do_push;
        logic do_pop;
        rst           = r;
        bus.in_valid  = iv;
        bus.op        = o;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = ordy;
        do_push = iv && (model_q.size() < DEPTH);
        do_pop  = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (r) begin
            model_q.delete();
            model_acc = 0;
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                model_q.push_back(ref_gate(o, a, b));
                if (model_acc < 65535) model_acc++;
            end
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    logic [WIDTH-1:0] ops_exp [8];
    logic [WIDTH-1:0] oldest;
    logic             iv_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r;

    initial begin
        truth = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b1100, 4'b0011};
        ops_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0, 8'h0F};
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
        @(negedge clk);

        step("rst0", 1, 0, 0, 0, 0, 0);
        step("rst1", 1, 1, 0, 8'hFF, 8'hFF, 1);
        check("reset.out_valid", 32'(bus.out_valid), 0);
        check("reset.in_ready",  32'(bus.in_ready),  1);
        check("reset.level",     32'(level),         0);
        check("reset.out2",      32'(bus.out2),      0);
        check("reset.acc_cnt",   32'(acc_cnt),       0);

        // Every op on fixed operands, one in and one out per cycle.
        for (int i = 0; i < 8; i++) begin
            step("ops", 0, 1, 3'(i), 8'hF0, 8'hCC, 1);
            check($sformatf("ops.op%0d", i), 32'(bus.out2), 32'(ops_exp[i]));
        end
        step("ops_drain", 0, 0, 0, 0, 0, 1);

        step("fill_rst", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step("fill", 0, 1, 3'($urandom_range(7)), 8'($urandom), 8'($urandom), 0);
            if (i == 3) check("fill.in_ready_4th", 32'(bus.in_ready), 0);
        end
        check("fill.level",   32'(level),   4);
        check("fill.acc_cnt", 32'(acc_cnt), 4);

        // Alternate pops and pushes so both pointers wrap.
        for (int i = 0; i < 8; i++) begin
            step("wrap", 0, (i % 2) == 1, 3'($urandom_range(7)), 8'($urandom), 8'($urandom), (i % 2) == 0);
        end
        check("wrap.level", 32'(level), 4);
        for (int i = 0; i < 4; i++) step("wrap_drain", 0, 0, 0, 0, 0, 1);
        check("wrap_drain.level", 32'(level), 0);

        step("sim_rst", 1, 0, 0, 0, 0, 0);
        step("sim_p0", 0, 1, 3'd2, 8'hA5, 8'h0F, 0);
        step("sim_p1", 0, 1, 3'd6, 8'h3C, 8'h00, 0);
        oldest = bus.out2;
        check("sim.oldest", 32'(oldest), 32'h000000AA);
        step("sim_pp", 0, 1, 3'd7, 8'h55, 8'h00, 1);
        check("sim.level", 32'(level), 2);
        check("sim.new_head", 32'(bus.out2), 32'h0000003C);

        step("mid_p", 0, 1, 3'd1, 8'h01, 8'h02, 0);
        check("mid.level3", 32'(level), 3);
        step("mid_rst", 1, 1, 3'd0, 8'hFF, 8'hFF, 1);
        check("mid.level0", 32'(level), 0);
        check("mid.out_valid0", 32'(bus.out_valid), 0);
        step("mid_push", 0, 1, 3'd4, 8'h12, 8'h34, 0);
        check("mid.out_valid1", 32'(bus.out_valid), 1);
        check("mid.out2", 32'(bus.out2), 32'h000000C9);

        // Random traffic; operands held while the producer is stalled.
        iv_r = 0; op_r = 0; a_r = 0; b_r = 0;
        for (int i = 0; i < 400; i++) begin
            if (!(iv_r && model_q.size() >= DEPTH)) begin
                iv_r = 1'($urandom_range(1));
                op_r = 3'($urandom_range(7));
                a_r  = 8'($urandom);
                b_r  = 8'($urandom);
            end
            step("rand", ($urandom_range(63) == 0), iv_r, op_r, a_r, b_r, 1'($urandom_range(1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
